hex_display_scan: RTL and testbench

//  Time-multiplexed hex driver for the Nexys 4 DDR 7-segment bank: shows a NUM_DIGITS-nibble value, one digit per scan slot.

---
 rtl/hex_display_scan.sv | 99 +++++++++
 tb/tb_hex_display_scan.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scan.sv
// rtl/hex_display_scan.sv - time-multiplexed hex driver for an active-low 7-segment bank
// Shadow-buffered value with frame-aligned loads, per-digit enable, DP, leading-zero blanking, dead-time.
module hex_display_scan #(
   parameter int NUM_DIGITS   = 8,
   parameter int TICK_DIV     = 12500,
   parameter int BLANK_CYCLES = 4,
   parameter int BLANK_LZ     = 1
) (
   input  logic                    CLK100MHZ,
   input  logic                    CPU_RESETN,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    load,
   output logic                    busy,
   output logic                    frame_start,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic [7:0]              Ca
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [PW-1:0]           presc;
   logic [IW-1:0]           idx;
   logic [4*NUM_DIGITS-1:0] pend_value, sh_value;
   logic [NUM_DIGITS-1:0]   pend_dp, pend_en, sh_dp, sh_en;
   logic [NUM_DIGITS-1:0]   lz;
   logic [3:0]              nib;
   logic                    slot_end, frame_end, lit;

   function automatic logic [6:0] seg7(input logic [3:0] h);
      case (h)
         4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
      endcase
   endfunction

   assign slot_end  = (presc == PW'(TICK_DIV - 1));
   assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));
   assign nib       = sh_value[{idx, 2'b00} +: 4];

   // lz[k] = 1 when digit k and every digit above it hold zero
   always_comb begin
      logic run;
      run = 1'b1;
      lz  = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         run   = run && (sh_value[4*k +: 4] == 4'h0);
         lz[k] = run;
      end
   end

   assign lit = (presc >= PW'(BLANK_CYCLES)) && sh_en[idx]
              && !((BLANK_LZ != 0) && (idx != '0) && lz[idx]);

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         presc       <= '0;
         idx         <= '0;
         pend_value  <= '0;
         pend_dp     <= '0;
         pend_en     <= '0;
         sh_value    <= '0;
         sh_dp       <= '0;
         sh_en       <= '0;
         busy        <= 1'b0;
         frame_start <= 1'b0;
         AN          <= '1;
         Ca          <= 8'hFF;
      end else begin
         presc <= slot_end ? '0 : presc + 1'b1;
         if (slot_end)
            idx <= frame_end ? '0 : idx + 1'b1;
         frame_start <= frame_end;

         // A load on the boundary cycle lands in pending and waits one more frame
         if (load) begin
            pend_value <= value;
            pend_dp    <= dp;
            pend_en    <= digit_en;
            busy       <= 1'b1;
         end else if (frame_end) begin
            busy <= 1'b0;
         end
         if (frame_end && busy) begin
            sh_value <= pend_value;
            sh_dp    <= pend_dp;
            sh_en    <= pend_en;
         end

         AN <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
         Ca <= lit ? {~sh_dp[idx], seg7(nib)} : 8'hFF;
      end
   end

endmodule

// File: tb/tb_hex_display_scan.sv
// tb/tb_hex_display_scan.sv - self-checking bench for hex_display_scan
module tb_hex_display_scan;

   localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   typedef struct packed {
      logic [15:0] v;
      logic [3:0]  d;
      logic [3:0]  e;
      logic [15:0] an4;
      logic [31:0] ca4;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp = '0;
   logic [3:0]  digit_en = '0;
   logic        load = 1'b0;
   logic        busy, frame_start;
   logic [3:0]  AN;
   logic [7:0]  Ca;

   int n_total = 0;
   int n_pass  = 0;

   int          cnt = 0;
   logic [15:0] m_sv = '0, m_pv = '0;
   logic [3:0]  m_sd = '0, m_se = '0, m_pd = '0, m_pe = '0;
   logic        m_busy = 1'b0;
   logic [3:0]  exp_an = 4'hF;
   logic [7:0]  exp_ca = 8'hFF;
   logic        exp_fs = 1'b0;

   hex_display_scan #(
      .NUM_DIGITS(4), .TICK_DIV(10), .BLANK_CYCLES(2), .BLANK_LZ(1)
   ) dut (
      .CLK100MHZ(clk), .CPU_RESETN(rst_n), .value(value), .dp(dp), .digit_en(digit_en),
      .load(load), .busy(busy), .frame_start(frame_start), .AN(AN), .Ca(Ca)
   );

   always #5 clk = ~clk;

   // What digit i shows at slot position p, straight from the display rules
   function automatic logic [11:0] disp(input logic [15:0] v, input logic [3:0] d,
                                        input logic [3:0] e, input int i, input int p);
      logic [15:0] upper;
      upper = v >> (4 * i);
      if (p < 2 || !e[i] || (i > 0 && upper == 16'h0)) return {4'hF, 8'hFF};
      return {~(4'b0001 << i), ~d[i], SEG[upper[3:0]]};
   endfunction

   // Cycle-count reference: slot = cnt/10, position = cnt%10, frame = 40 cycles
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 0;
         m_sv <= '0; m_sd <= '0; m_se <= '0;
         m_pv <= '0; m_pd <= '0; m_pe <= '0;
         m_busy <= 1'b0;
         exp_an <= 4'hF; exp_ca <= 8'hFF; exp_fs <= 1'b0;
      end else begin
         {exp_an, exp_ca} <= disp(m_sv, m_sd, m_se, (cnt / 10) % 4, cnt % 10);
         exp_fs <= (cnt % 40 == 39);
         if (load) begin
            m_pv <= value; m_pd <= dp; m_pe <= digit_en; m_busy <= 1'b1;
         end else if (cnt % 40 == 39) begin
            m_busy <= 1'b0;
         end
         if (cnt % 40 == 39 && m_busy) begin
            m_sv <= m_pv; m_sd <= m_pd; m_se <= m_pe;
         end
         cnt <= cnt + 1;
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(negedge clk);
      cmp("an", 32'(AN), 32'(exp_an));
      cmp("ca", 32'(Ca), 32'(exp_ca));
      cmp("frame_start", 32'(frame_start), 32'(exp_fs));
      cmp("busy", 32'(busy), 32'(m_busy));
      cmp("an_onehot", 32'($countones(~AN) <= 1), 32'd1);
   endtask

   task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
      value = v; dp = d; digit_en = e; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic wait_frame();
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
         step();
         if (frame_start && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      cmp("frame_wait", 32'(ok), 32'd1);
   endtask

   initial begin
      vec_t tbl [7];
      logic ok;
      logic seen_one;
      tbl[0] = '{16'h1A2F, 4'b0100, 4'hF, 16'h7BDE, 32'hF908A48E};
      tbl[1] = '{16'h0030, 4'b0000, 4'hF, 16'hFFDE, 32'hFFFFB0C0};
      tbl[2] = '{16'h0000, 4'b0000, 4'hF, 16'hFFFE, 32'hFFFFFFC0};
      tbl[3] = '{16'hC0DE, 4'b1001, 4'b1010, 16'h7FDF, 32'h46FFA1FF};
      tbl[4] = '{16'h0705, 4'b0010, 4'hF, 16'hFBDE, 32'hFFF84092};
      tbl[5] = '{16'h3649, 4'b0000, 4'hF, 16'h7BDE, 32'hB0829990};
      tbl[6] = '{16'h0000, 4'b1111, 4'hF, 16'hFFFE, 32'hFFFFFF40};

      repeat (3) step();
      cmp("reset_an", 32'(AN), 32'hF);
      cmp("reset_ca", 32'(Ca), 32'hFF);
      rst_n = 1'b1;
      repeat (12) step();

      for (int t = 0; t < 7; t++) begin
         drive_load(tbl[t].v, tbl[t].d, tbl[t].e);
         wait_frame();
         repeat (5) step();
         for (int s = 0; s < 4; s++) begin
            cmp($sformatf("tbl%0d_an%0d", t, s), 32'(AN), 32'(tbl[t].an4[4*s +: 4]));
            cmp($sformatf("tbl%0d_ca%0d", t, s), 32'(Ca), 32'(tbl[t].ca4[8*s +: 8]));
            if (s < 3) repeat (10) step();
         end
      end

      // Reset while digit 0 of the next frame is lit
      repeat (10) step();
      cmp("pre_reset_lit", 32'(AN), 32'hE);
      #2 rst_n = 1'b0;
      #1;
      cmp("midscan_rst_an", 32'(AN), 32'hF);
      cmp("midscan_rst_ca", 32'(Ca), 32'hFF);
      cmp("midscan_rst_busy", 32'(busy), 32'd0);
      cmp("midscan_rst_fs", 32'(frame_start), 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (5) step();
      drive_load(16'h0000, 4'h0, 4'hF);
      wait_frame();
      step(); cmp("first_slot_c1", 32'(AN), 32'hF);
      step(); cmp("first_slot_c2", 32'(AN), 32'hF);
      step(); cmp("first_slot_c3", 32'(AN), 32'hE);

      // Tear-free update
      drive_load(16'h1A2F, 4'b0100, 4'hF);
      wait_frame();
      repeat (15) step();
      drive_load(16'h0005, 4'h0, 4'hF);
      cmp("tear_busy_set", 32'(busy), 32'd1);
      ok = 1'b0;
      for (int n = 0; n < 60; n++) begin
         step();
         if (frame_start) begin
            ok = 1'b1;
            break;
         end
         cmp("tear_busy_hold", 32'(busy), 32'd1);
      end
      cmp("tear_fs_seen", 32'(ok), 32'd1);
      cmp("tear_busy_clear", 32'(busy), 32'd0);
      repeat (5) step();
      cmp("tear_new_an", 32'(AN), 32'hE);
      cmp("tear_new_ca", 32'(Ca), 32'h92);

      // Back-to-back loads: only the last reaches the display
      repeat (10) step();
      drive_load(16'h1111, 4'h0, 4'hF);
      repeat (3) step();
      drive_load(16'h2222, 4'h0, 4'hF);
      wait_frame();
      repeat (5) step();
      cmp("b2b_ca0", 32'(Ca), 32'hA4);
      seen_one = 1'b0;
      for (int n = 0; n < 40; n++) begin
         step();
         if (Ca[6:0] == 7'h79) seen_one = 1'b1;
      end
      cmp("b2b_no_1111", 32'(seen_one), 32'd0);

      // Random loads at random times against the reference
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            drive_load(16'($urandom), 4'($urandom), 4'($urandom));
         end else begin
            value = 16'($urandom); dp = 4'($urandom); digit_en = 4'($urandom);
            step();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
